// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: one TCDM memory bank seen from one interconnect master port.
// Provides word storage, a fixed response latency and optional periodic grant throttling.
//
// Handshake: a transaction is accepted in any cycle where req_i and gnt_o are both high
// (gnt_o is combinational from req_i, stall_i, rst_i and the throttle state). The master
// holds add_i/wen_i/wdata_i/be_i stable while req_i is high and gnt_o is low. Every accepted
// transaction returns exactly one r_valid_o pulse RD_LATENCY cycles after its grant cycle,
// in grant order; the response cannot be back-pressured.
module tcdm_bank_responder #(
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned MEM_WORDS        = 1024,
   parameter int unsigned RD_LATENCY       = 1,
   parameter int unsigned GNT_STALL_PERIOD = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   input  logic [ADDR_WIDTH-1:0]     add_i,
   input  logic                      wen_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic                      stall_i,
   output logic                      gnt_o,
   output logic                      r_valid_o,
   output logic [DATA_WIDTH-1:0]     r_rdata_o,
   output logic                      r_err_o,
   output logic [31:0]               txn_count_o
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned OFF_W    = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
   localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned HI_LSB   = OFF_W + IDX_W;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } thr_state_e;

   // Throttle state is kept in named registers so checkers can bind to them directly.
   thr_state_e            thr_state_q, thr_state_d;
   logic [31:0]           gnt_cnt_q, gnt_cnt_d;
   logic                  throttle;

   logic                  accept;
   logic                  out_of_range;
   logic [IDX_W-1:0]      word_idx;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic                  rsp_valid_d;
   logic                  rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_data_d;
   logic                  pipe_valid_q [RD_LATENCY];
   logic                  pipe_err_q   [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_data_q  [RD_LATENCY];

   logic [31:0]           txn_count_q;

   assign word_idx = add_i[OFF_W +: IDX_W];

   generate
      if (HI_LSB < ADDR_WIDTH) begin : g_range_chk
         assign out_of_range = |add_i[ADDR_WIDTH-1:HI_LSB];
      end else begin : g_no_range_chk
         assign out_of_range = 1'b0;
      end
      if (OFF_W > 0) begin : g_lsb
         // Byte-offset bits do not select anything in a word-wide bank.
         logic unused_addr_lsb;
         assign unused_addr_lsb = ^add_i[OFF_W-1:0];
      end
   endgenerate

   assign throttle = (thr_state_q == ST_HOLD);
   assign gnt_o    = req_i & ~stall_i & ~throttle & ~rst_i;
   assign accept   = req_i & gnt_o;

   // Throttle FSM next state: count grants in RUN, spend exactly one cycle in HOLD.
   always_comb begin
      thr_state_d = thr_state_q;
      gnt_cnt_d   = gnt_cnt_q;
      case (thr_state_q)
         ST_RUN: begin
            if ((GNT_STALL_PERIOD != 0) && accept) begin
               if (gnt_cnt_q == 32'(GNT_STALL_PERIOD - 1)) begin
                  thr_state_d = ST_HOLD;
                  gnt_cnt_d   = 32'd0;
               end else begin
                  gnt_cnt_d = gnt_cnt_q + 32'd1;
               end
            end
         end
         ST_HOLD: begin
            thr_state_d = ST_RUN;
         end
         default: begin
            thr_state_d = ST_RUN;
            gnt_cnt_d   = 32'd0;
         end
      endcase
   end

   // Throttle FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         thr_state_q <= ST_RUN;
         gnt_cnt_q   <= 32'd0;
      end else begin
         thr_state_q <= thr_state_d;
         gnt_cnt_q   <= gnt_cnt_d;
      end
   end

   // Commit the enabled bytes of an accepted in-range write; storage is never reset.
   always_ff @(posedge clk_i) begin
      if (accept && !wen_i && !out_of_range) begin
         for (int unsigned k = 0; k < BE_WIDTH; k++) begin
            if (be_i[k]) begin
               mem_q[word_idx][k*8 +: 8] <= wdata_i[k*8 +: 8];
            end
         end
      end
   end

   // Response entering the pipeline: read data sampled at the grant edge, zero otherwise.
   always_comb begin
      rsp_valid_d = accept;
      rsp_err_d   = accept & out_of_range;
      rsp_data_d  = '0;
      if (accept && wen_i && !out_of_range) begin
         rsp_data_d = mem_q[word_idx];
      end
   end

   // Response shift register; reset drops everything in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            pipe_valid_q[i] <= 1'b0;
            pipe_err_q[i]   <= 1'b0;
            pipe_data_q[i]  <= '0;
         end
      end else begin
         pipe_valid_q[0] <= rsp_valid_d;
         pipe_err_q[0]   <= rsp_err_d;
         pipe_data_q[0]  <= rsp_data_d;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_err_q[i]   <= pipe_err_q[i-1];
            pipe_data_q[i]  <= pipe_data_q[i-1];
         end
      end
   end

   // Count accepted transactions, wrapping naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         txn_count_q <= 32'd0;
      end else if (accept) begin
         txn_count_q <= txn_count_q + 32'd1;
      end
   end

   assign r_valid_o   = pipe_valid_q[RD_LATENCY-1];
   assign r_err_o     = pipe_valid_q[RD_LATENCY-1] & pipe_err_q[RD_LATENCY-1];
   assign r_rdata_o   = pipe_valid_q[RD_LATENCY-1] ? pipe_data_q[RD_LATENCY-1] : '0;
   assign txn_count_o = txn_count_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Testbench for tcdm_bank_responder: three instances cover latency 1, latency 3 and
// grant throttling with period 2. Inputs change on the falling edge, outputs are
// sampled on the falling edge (gnt_o one step after the inputs settle).
module tb_tcdm_bank_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst    [N];
  logic        req    [N];
  logic [31:0] add    [N];
  logic        wen    [N];
  logic [31:0] wdata  [N];
  logic [3:0]  be     [N];
  logic        stall  [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        rerr   [N];
  logic [31:0] txn    [N];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  tcdm_bank_responder #(.MEM_WORDS(16), .RD_LATENCY(1), .GNT_STALL_PERIOD(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .add_i(add[0]), .wen_i(wen[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .stall_i(stall[0]), .gnt_o(gnt[0]),
    .r_valid_o(rvalid[0]), .r_rdata_o(rdata[0]), .r_err_o(rerr[0]), .txn_count_o(txn[0]));

  tcdm_bank_responder #(.MEM_WORDS(16), .RD_LATENCY(3), .GNT_STALL_PERIOD(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .add_i(add[1]), .wen_i(wen[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .stall_i(stall[1]), .gnt_o(gnt[1]),
    .r_valid_o(rvalid[1]), .r_rdata_o(rdata[1]), .r_err_o(rerr[1]), .txn_count_o(txn[1]));

  tcdm_bank_responder #(.MEM_WORDS(16), .RD_LATENCY(1), .GNT_STALL_PERIOD(2)) u_dut_c (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .add_i(add[2]), .wen_i(wen[2]),
    .wdata_i(wdata[2]), .be_i(be[2]), .stall_i(stall[2]), .gnt_o(gnt[2]),
    .r_valid_o(rvalid[2]), .r_rdata_o(rdata[2]), .r_err_o(rerr[2]), .txn_count_o(txn[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int i, input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] b);
    req[i]   = r;
    add[i]   = a;
    wen[i]   = w;
    wdata[i] = d;
    be[i]    = b;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
  endtask

  // One isolated transaction on a latency-1 instance, response checked one cycle later.
  task automatic single(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                        input string tag);
    @(negedge clk);
    drive(i, 1'b1, a, w, d, b);
    #1 check_eq({tag, " gnt"}, gnt[i], 1);
    @(negedge clk);
    check_eq({tag, " rvalid"}, rvalid[i], 1);
    check_eq({tag, " rdata"}, rdata[i], exp_d);
    check_eq({tag, " rerr"}, rerr[i], exp_e);
    idle(i);
  endtask

  logic [11:0] exp_gnt_v = 12'b1101_0101_1011;
  logic [11:0] stall_v   = 12'b0000_1000_0000;
  logic        prev_g;

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i]   = 1'b1;
      stall[i] = 1'b0;
      idle(i);
    end

    // reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq("rst rvalid", rvalid[i], 0);
      check_eq("rst rdata", rdata[i], 0);
      check_eq("rst rerr", rerr[i], 0);
      check_eq("rst txn", txn[i], 0);
    end
    drive(2, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
    #1 check_eq("rst gnt blocked", gnt[2], 0);
    @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    idle(2);

    // T1: write then read the same word back to back
    @(negedge clk);
    drive(0, 1'b1, 32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
    #1 check_eq("t1 wr gnt", gnt[0], 1);
    @(negedge clk);
    check_eq("t1 wr rvalid", rvalid[0], 1);
    check_eq("t1 wr rdata", rdata[0], 0);
    check_eq("t1 wr rerr", rerr[0], 0);
    drive(0, 1'b1, 32'h10, 1'b1, 32'h0, 4'h0);
    #1 check_eq("t1 rd gnt", gnt[0], 1);
    @(negedge clk);
    check_eq("t1 rd rvalid", rvalid[0], 1);
    check_eq("t1 rd rdata", rdata[0], 32'hDEADBEEF);
    idle(0);
    @(negedge clk);
    check_eq("t1 idle rvalid", rvalid[0], 0);
    check_eq("t1 idle rdata", rdata[0], 0);

    // T2: partial write and a be=0 no-op write
    single(0, 32'h20, 1'b0, 32'h11223344, 4'hF, 32'h0, 1'b0, "t2 wr full");
    single(0, 32'h20, 1'b0, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, "t2 wr byte1");
    single(0, 32'h20, 1'b1, 32'h0, 4'h0, 32'h1122AB44, 1'b0, "t2 rd");
    single(0, 32'h20, 1'b0, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, "t2 wr be0");
    single(0, 32'h20, 1'b1, 32'h0, 4'h0, 32'h1122AB44, 1'b0, "t2 rd after be0");

    // T5: out-of-range accesses leave the whole bank intact
    for (int k = 0; k < 16; k++)
      single(0, 32'(k * 4), 1'b0, 32'hA500_0000 | 32'(k), 4'hF, 32'h0, 1'b0, "t5 fill");
    single(0, 32'h40, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "t5 oor wr");
    single(0, 32'h44, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, "t5 oor rd");
    single(0, 32'h8000_0000, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, "t5 oor rd msb");
    for (int k = 0; k < 16; k++)
      single(0, 32'(k * 4), 1'b1, 32'h0, 4'h0, 32'hA500_0000 | 32'(k), 1'b0, "t5 readback");
    @(negedge clk);
    check_eq("t5 txn", txn[0], 42);

    // T3: latency 3, preload words then reset (storage survives), then 4 back-to-back reads
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 1'b1, 32'(c * 4), 1'b0, 32'hC0DE_0000 + 32'(c), 4'hF);
      #1 check_eq("t3 wr gnt", gnt[1], 1);
    end
    @(negedge clk);
    idle(1);
    repeat (4) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check_eq("t3 txn after rst", txn[1], 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid[1]) begin
        check_eq("t3 resp expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("t3 rdata", rdata[1], exp_q.pop_front());
      end
      check_eq("t3 rvalid", rvalid[1], 32'(c >= 3 && c <= 6));
      if (c < 4) begin
        drive(1, 1'b1, 32'(c * 4), 1'b1, 32'h0, 4'h0);
        #1 check_eq("t3 rd gnt", gnt[1], 1);
        exp_q.push_back(32'hC0DE_0000 + 32'(c));
      end else begin
        idle(1);
      end
    end
    check_eq("t3 queue drained", exp_q.size(), 0);
    check_eq("t3 txn", txn[1], 4);

    // T6: reset with two reads in flight and a request held across release
    @(negedge clk);
    drive(1, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0);
    #1 check_eq("t6 gnt0", gnt[1], 1);
    @(negedge clk);
    drive(1, 1'b1, 32'h4, 1'b1, 32'h0, 4'h0);
    #1 check_eq("t6 gnt1", gnt[1], 1);
    @(negedge clk);
    drive(1, 1'b1, 32'h8, 1'b1, 32'h0, 4'h0);
    rst[1] = 1'b1;
    #1 check_eq("t6 gnt in rst", gnt[1], 0);
    @(negedge clk);
    rst[1] = 1'b0;
    check_eq("t6 rvalid after rst", rvalid[1], 0);
    check_eq("t6 txn after rst", txn[1], 0);
    #1 check_eq("t6 gnt on release", gnt[1], 1);
    @(negedge clk);
    idle(1);
    check_eq("t6 dropped 1", rvalid[1], 0);
    @(negedge clk);
    check_eq("t6 dropped 2", rvalid[1], 0);
    @(negedge clk);
    check_eq("t6 held rvalid", rvalid[1], 1);
    check_eq("t6 held rdata", rdata[1], 32'hC0DE_0002);
    @(negedge clk);
    check_eq("t6 tail rvalid", rvalid[1], 0);
    check_eq("t6 txn", txn[1], 1);

    // T4: throttle period 2 with one stall cycle in the second round
    prev_g = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check_eq("t4 rvalid", rvalid[2], 32'(prev_g));
      if (c < 12) begin
        drive(2, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
        stall[2] = stall_v[c];
        #1 check_eq("t4 gnt", gnt[2], 32'(exp_gnt_v[c]));
        prev_g = exp_gnt_v[c];
      end else begin
        idle(2);
        stall[2] = 1'b0;
      end
    end
    check_eq("t4 txn", txn[2], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
